// File: rtl/m92_pkg.sv
// Shared types for the m92 SDRAM path: write-combiner word record, merge
// decision kinds and a lane-overlay helper.
package m92_pkg;

    typedef struct packed {
        logic [24:1] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } sdr_wr_t;

    typedef enum logic [1:0] {
        MERGE_LOAD,
        MERGE_SAME,
        MERGE_NEW
    } merge_kind_e;

    localparam logic [1:0] BE_FULL = 2'b11;

    function automatic logic [15:0] mergeLanes(input logic [15:0] oldData,
                                               input logic [15:0] newData,
                                               input logic [1:0]  be);
        mergeLanes = {be[1] ? newData[15:8] : oldData[15:8],
                      be[0] ? newData[7:0]  : oldData[7:0]};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; the head word is visible on
// dout whenever the FIFO is non-empty. A push while full succeeds only with a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic             doPush;
    logic             doPop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_FULL);
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign dout   = mem_q[rdPtr_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clock) begin
        if (doPush) mem_q[wrPtr_q] <= din;
    end

endmodule

// File: rtl/sdr_write_merge.sv
// Write-combining stage between the ROM loader byte-write port and the SDRAM
// controller: pairs byte lanes into words, queues them, issues one write per word.
module sdr_write_merge
    import m92_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [24:0] in_addr,
    input  logic [15:0] in_data,
    input  logic [1:0]  in_be,
    input  logic        in_req,
    output logic        in_rdy,
    input  logic        flush,
    output logic [24:0] out_addr,
    output logic [15:0] out_data,
    output logic [1:0]  out_be,
    output logic        out_req,
    input  logic        out_rdy,
    output logic        idle
);
    sdr_wr_t     pend_q, pend_d;
    logic        pendValid_q, pendValid_d;
    logic        flushPend_q, flushPend_d;
    logic        holdoff_q;
    sdr_wr_t     outWord_q;
    logic        outReq_q;

    sdr_wr_t     inWord;
    sdr_wr_t     mergedWord;
    sdr_wr_t     pushWord;
    sdr_wr_t     fifoDin;
    sdr_wr_t     fifoDout;
    merge_kind_e mergeKind;
    logic        pushNeeded;
    logic        accept;
    logic        flushService;
    logic        fifoPush;
    logic        fifoPop;
    logic        fifoFull;
    logic        fifoEmpty;
    logic        unusedAddrLsb;

    assign unusedAddrLsb = in_addr[0];

    assign inWord     = '{addr: in_addr[24:1], data: in_data, be: in_be};
    assign mergedWord = '{addr: pend_q.addr,
                          data: mergeLanes(pend_q.data, in_data, in_be),
                          be:   pend_q.be | in_be};

    always_comb begin
        mergeKind  = MERGE_LOAD;
        pushNeeded = 1'b0;
        pushWord   = inWord;
        if (!pendValid_q) begin
            mergeKind  = MERGE_LOAD;
            pushNeeded = (in_be == BE_FULL);
            pushWord   = inWord;
        end else if (in_addr[24:1] == pend_q.addr) begin
            mergeKind  = MERGE_SAME;
            pushNeeded = (mergedWord.be == BE_FULL);
            pushWord   = mergedWord;
        end else begin
            mergeKind  = MERGE_NEW;
            pushNeeded = 1'b1;
            pushWord   = pend_q;
        end
    end

    // A flush only gets a cycle the accept path leaves unused, so accepts win.
    assign accept       = in_req & ~holdoff_q & (~pushNeeded | ~fifoFull);
    assign flushService = flushPend_q & ~accept & ~fifoFull;

    always_comb begin
        pend_d      = pend_q;
        pendValid_d = pendValid_q;
        fifoPush    = 1'b0;
        fifoDin     = pushWord;
        if (accept) begin
            fifoPush = pushNeeded;
            case (mergeKind)
                MERGE_LOAD: begin
                    pend_d      = inWord;
                    pendValid_d = ~pushNeeded;
                end
                MERGE_SAME: begin
                    pend_d      = mergedWord;
                    pendValid_d = ~pushNeeded;
                end
                default: begin
                    pend_d      = inWord;
                    pendValid_d = 1'b1;
                end
            endcase
        end else if (flushService) begin
            fifoPush    = pendValid_q;
            fifoDin     = pend_q;
            pendValid_d = 1'b0;
        end
        flushPend_d = (flushPend_q & ~flushService) | flush;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pend_q      <= '0;
            pendValid_q <= 1'b0;
            flushPend_q <= 1'b0;
            holdoff_q   <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pendValid_q <= pendValid_d;
            flushPend_q <= flushPend_d;
            holdoff_q   <= accept;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(sdr_wr_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (sys_clk),
        .reset (reset),
        .push  (fifoPush),
        .pop   (fifoPop),
        .din   (fifoDin),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    assign fifoPop = ~fifoEmpty & (~outReq_q | out_rdy);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            outWord_q <= '0;
            outReq_q  <= 1'b0;
        end else if (fifoPop) begin
            outWord_q <= fifoDout;
            outReq_q  <= 1'b1;
        end else if (out_rdy) begin
            outReq_q  <= 1'b0;
        end
    end

    assign in_rdy   = holdoff_q;
    assign out_addr = {outWord_q.addr, 1'b0};
    assign out_data = outWord_q.data;
    assign out_be   = outWord_q.be;
    assign out_req  = outReq_q;
    assign idle     = ~pendValid_q & fifoEmpty & ~outReq_q & ~flushPend_q & ~holdoff_q;

endmodule
